fetch_unit: RTL and testbench

- Instruction fetch stage for the RV32I core.
- Owns the program counter and issues one instruction-memory read at a time.
- Holds each returned instruction, with its PC and PC+4, in a single-entry output buffer until decode accepts it through a valid/ready handshake.
- Handles branch/jump redirects from execute, including discarding in-flight wrong-path responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_add.sv | 12 +
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [31:0] INSN_BYTES = 32'd4;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_add.sv
// Plain modulo-2^W adder shared by the fetch stage for its PC increment.
module fetch_unit_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one imem read in flight and buffers
// one instruction for decode.
//
// Handshakes: decode consumes inst_o on a rising edge where inst_valid_o and
// inst_ready_i are both 1; inst_o/inst_pc_o/inst_pc_four_o stay stable while
// inst_valid_o=1 and inst_ready_i=0. imem_req_o is a one-cycle pulse with
// imem_addr_o valid in that cycle; imem_rvalid_i may arrive any later cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_pc_four_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         valid_q, valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [31:0]  ipc_four_q, ipc_four_d;
  logic [31:0]  pc_plus_four;

  fetch_unit_add #(.W(32)) u_pc_add (
    .a_i   (pc_q),
    .b_i   (INSN_BYTES),
    .sum_o (pc_plus_four)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    ipc_four_d = ipc_four_q;

    // A redirect wins over every other event; only the fate of the
    // in-flight read depends on the current state.
    if (br_taken_i) begin
      pc_d    = align_word(br_target_i);
      valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
          drop_d  = 1'b1;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              inst_d     = imem_rdata_i;
              ipc_d      = pc_q;
              ipc_four_d = pc_plus_four;
              pc_d       = pc_plus_four;
              valid_d    = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end
        default: begin
          if (valid_q && inst_ready_i) begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INSN;
      ipc_q      <= 32'h0000_0000;
      ipc_four_q <= INSN_BYTES;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      ipc_four_q <= ipc_four_d;
    end
  end

  assign imem_req_o     = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o    = pc_q;
  assign inst_valid_o   = valid_q;
  assign inst_o         = inst_q;
  assign inst_pc_o      = ipc_q;
  assign inst_pc_four_o = ipc_four_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a transaction
// level model compared against the main instance every cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] inst, ipc, ipc4;

  logic        rst_w = 1'b1;
  logic        rvalid_w = 1'b0;
  logic [31:0] rdata_w = '0;
  logic        ready_w = 1'b1;
  logic        req_w;
  logic [31:0] addr_w;
  logic        valid_w;
  logic [31:0] inst_w, ipc_w, ipc4_w;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk_i(clk), .rst_i(rst), .br_taken_i(br), .br_target_i(tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .inst_valid_o(valid), .inst_ready_i(ready),
    .inst_o(inst), .inst_pc_o(ipc), .inst_pc_four_o(ipc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst_w), .br_taken_i(1'b0), .br_target_i(32'h0),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_rvalid_i(rvalid_w),
    .imem_rdata_i(rdata_w), .inst_valid_o(valid_w), .inst_ready_i(ready_w),
    .inst_o(inst_w), .inst_pc_o(ipc_w), .inst_pc_four_o(ipc4_w)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("wait_valid_timeout", {31'b0, valid}, 32'd1);
  endtask

  // Instruction memory for the main instance: programmable fixed latency.
  initial begin : mem_main
    logic [31:0] paddr;
    int          cnt;
    logic        pend;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      if (req && !rst) begin
        paddr = addr;
        cnt   = mem_lat;
        pend  = 1'b1;
      end
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          rvalid = 1'b1;
          rdata  = mem_fn(paddr);
          pend   = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Instruction memory for the wrap instance: one-cycle latency.
  initial begin : mem_wrap
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (req_w && !rst_w) begin
        a = addr_w;
        @(posedge clk);
        #1;
        rvalid_w = 1'b1;
        rdata_w  = mem_fn(a);
        @(posedge clk);
        #1;
        rvalid_w = 1'b0;
      end
    end
  end

  // Transaction model: a read is issued whenever nothing is outstanding and
  // nothing is buffered; a redirect marks any in-flight read as wrong-path.
  initial begin : model_cmp
    logic        live, busy, stale, m_valid, issued;
    logic [31:0] m_fetch, m_inst, m_pc, m_pc4;
    live = 1'b0; busy = 1'b0; stale = 1'b0; m_valid = 1'b0;
    m_fetch = 32'h1000; m_inst = NOP; m_pc = '0; m_pc4 = 32'd4;
    forever begin
      @(negedge clk);
      if (live) begin
        issued = !rst && !busy && !m_valid;
        check("m_req", {31'b0, req}, {31'b0, issued});
        if (issued) check("m_addr", addr, m_fetch);
        check("m_valid", {31'b0, valid}, {31'b0, m_valid});
        if (m_valid) begin
          check("m_inst", inst, m_inst);
          check("m_pc", ipc, m_pc);
          check("m_pc4", ipc4, m_pc4);
        end
      end
      if (rst) begin
        live = 1'b1; busy = 1'b0; stale = 1'b0; m_valid = 1'b0;
        m_fetch = 32'h1000; m_inst = NOP; m_pc = '0; m_pc4 = 32'd4;
      end else begin
        issued = !busy && !m_valid;
        if (br) begin
          m_fetch = {tgt[31:2], 2'b00};
          m_valid = 1'b0;
          if (issued) begin
            busy = 1'b1; stale = 1'b1;
          end else if (busy) begin
            if (rvalid) begin busy = 1'b0; stale = 1'b0; end
            else stale = 1'b1;
          end
        end else if (issued) begin
          busy = 1'b1; stale = 1'b0;
        end else if (busy && rvalid) begin
          busy = 1'b0;
          if (!stale) begin
            m_valid = 1'b1;
            m_inst  = mem_fn(m_fetch);
            m_pc    = m_fetch;
            m_pc4   = m_fetch + 32'd4;
            m_fetch = m_fetch + 32'd4;
          end
          stale = 1'b0;
        end else if (m_valid && ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int cyc;
    int seen_valid;

    // 1. Reset and first fetch with one-cycle memory.
    repeat (3) tick();
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc", ipc, 32'h0);
    check("rst_pc4", ipc4, 32'h4);
    rst = 1'b0;
    #1;
    check("t1_req", {31'b0, req}, 32'd1);
    check("t1_addr", addr, 32'h0000_1000);
    wait_valid(cyc);
    check("t1_latency", cyc, 32'd2);
    check("t1_pc", ipc, 32'h0000_1000);
    check("t1_pc4", ipc4, 32'h0000_1004);
    check("t1_inst", inst, 32'hC0DE_1000);
    mem_lat = 3;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_next_req", {31'b0, req}, 32'd1);
    check("t1_next_addr", addr, 32'h0000_1004);

    // 3. Redirect while the read of 0x1004 is outstanding.
    tick();
    br = 1'b1;
    tgt = 32'h0000_2002;
    tick();
    br = 1'b0;
    cyc = 0;
    seen_valid = 0;
    while (!req && cyc < 20) begin
      if (valid) seen_valid++;
      tick();
      cyc++;
    end
    check("t3_no_valid", seen_valid, 32'd0);
    check("t3_req", {31'b0, req}, 32'd1);
    check("t3_addr", addr, 32'h0000_2000);
    wait_valid(cyc);
    check("t3_pc", ipc, 32'h0000_2000);
    check("t3_inst", inst, 32'hC0DE_2000);

    // 2. Decode backpressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", {31'b0, valid}, 32'd1);
      check("t2_hold_inst", inst, 32'hC0DE_2000);
      check("t2_hold_pc", ipc, 32'h0000_2000);
      check("t2_hold_noreq", {31'b0, req}, 32'd0);
    end
    mem_lat = 1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_req", {31'b0, req}, 32'd1);
    check("t2_addr", addr, 32'h0000_2004);

    // 4. Redirect in the hold state together with ready.
    wait_valid(cyc);
    check("t4_pc_before", ipc, 32'h0000_2004);
    br = 1'b1;
    tgt = 32'h0000_3000;
    ready = 1'b1;
    tick();
    br = 1'b0;
    ready = 1'b0;
    check("t4_valid_drop", {31'b0, valid}, 32'd0);
    check("t4_req", {31'b0, req}, 32'd1);
    check("t4_addr", addr, 32'h0000_3000);
    wait_valid(cyc);
    check("t4_pc", ipc, 32'h0000_3000);
    check("t4_pc4", ipc4, 32'h0000_3004);

    // 6. Reset while waiting on memory; the late response lands during reset.
    mem_lat = 3;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t6_req", addr, 32'h0000_3004);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_rst_valid", {31'b0, valid}, 32'd0);
      check("t6_rst_req", {31'b0, req}, 32'd0);
    end
    check("t6_rst_inst", inst, NOP);
    check("t6_rst_pc", ipc, 32'h0);
    check("t6_rst_pc4", ipc4, 32'h4);
    rst = 1'b0;
    #1;
    check("t6_restart_req", {31'b0, req}, 32'd1);
    check("t6_restart_addr", addr, 32'h0000_1000);
    wait_valid(cyc);
    check("t6_pc", ipc, 32'h0000_1000);
    check("t6_inst", inst, 32'hC0DE_1000);

    // 5. PC wrap-around on the second instance.
    rst_w = 1'b0;
    cyc = 0;
    while (!valid_w && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t5_valid", {31'b0, valid_w}, 32'd1);
    check("t5_pc", ipc_w, 32'hFFFF_FFFC);
    check("t5_pc4", ipc4_w, 32'h0000_0000);
    check("t5_inst", inst_w, 32'h3F21_FFFC);
    tick();
    check("t5_req", {31'b0, req_w}, 32'd1);
    check("t5_addr", addr_w, 32'h0000_0000);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
